bist_tpg_controller: RTL and testbench

//  Test-pattern-generation half of the BIST loop. Drives pseudo-random patterns from a Fibonacci LFSR into the CUT.

---
 rtl/bist_tpg_controller.sv | 155 +++++++++++++++
 tb/tb_bist_tpg_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_tpg_controller.sv
// BIST test-pattern controller: drives LFSR patterns into the CUT and
// sequences the MISR, then checks the final signature against GOLDEN.
module bist_tpg_controller #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
    parameter int               CNT_W       = 8,
    parameter int               CUT_LATENCY = 0,
    parameter int               SIG_W       = 4,
    parameter logic [SIG_W-1:0] GOLDEN      = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             hold,
    input  logic [SIG_W-1:0] signature_in,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             misr_reset,
    output logic             misr_enable,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    // N for num_patterns == 0 is the full LFSR period, clipped to the counter
    localparam logic [CNT_W-1:0] N_MAX =
        (WIDTH >= CNT_W) ? {CNT_W{1'b1}}
                         : CNT_W'((64'd1 << WIDTH) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] LFSR_ONE = WIDTH'(1);

    localparam int FL_W = (CUT_LATENCY > 1) ? $clog2(CUT_LATENCY) : 1;
    localparam logic [FL_W-1:0] FL_LAST =
        FL_W'((CUT_LATENCY > 0) ? CUT_LATENCY - 1 : 0);
    localparam logic [FL_W-1:0] FL_ONE = FL_W'(1);

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] pattern_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_q;
    logic [FL_W-1:0]  fcnt;
    logic             misr_reset_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             last_pat;

    function automatic logic [WIDTH-1:0] lfsr_step(
        input logic [WIDTH-1:0] v
    );
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    assign lfsr_next = lfsr_step(lfsr);
    assign last_pat  = (cnt == (n_q - CNT_ONE));

    // Sequencer: run FSM, LFSR, pattern/flush counters and registered flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_ONE;
            pattern_q    <= '0;
            cnt          <= '0;
            n_q          <= '0;
            fcnt         <= '0;
            misr_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_CLEAR;
                        lfsr         <= (seed == '0) ? LFSR_ONE : seed;
                        cnt          <= '0;
                        fcnt         <= '0;
                        n_q          <= (num_patterns == '0) ? N_MAX
                                                             : num_patterns;
                        misr_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state        <= S_RUN;
                    misr_reset_q <= 1'b0;
                    pattern_q    <= lfsr;
                end
                S_RUN: begin
                    if (!hold) begin
                        lfsr <= lfsr_next;
                        cnt  <= cnt + CNT_ONE;
                        if (last_pat) begin
                            fcnt  <= '0;
                            state <= (CUT_LATENCY == 0) ? S_COMPARE
                                                        : S_FLUSH;
                        end else begin
                            pattern_q <= lfsr_next;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!hold) begin
                        if (fcnt == FL_LAST) begin
                            state <= S_COMPARE;
                        end else begin
                            fcnt <= fcnt + FL_ONE;
                        end
                    end
                end
                S_COMPARE: begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (signature_in == GOLDEN);
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Live-vector strobes drop in the same cycle hold is raised
    always_comb begin
        pattern_valid = 1'b0;
        misr_enable   = 1'b0;
        if (!hold) begin
            pattern_valid = (state == S_RUN);
            misr_enable   = (state == S_RUN) || (state == S_FLUSH);
        end
    end

    assign pattern    = pattern_q;
    assign misr_reset = misr_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_bist_tpg_controller.sv
// Directed bench for bist_tpg_controller: pattern order, hold, restart,
// reset mid-run, signature pass/fail and CUT latency flush.
module tb_bist_tpg_controller;

    function automatic logic [3:0] misr_step(
        input logic [3:0] m,
        input logic [3:0] d
    );
        return {m[2:0], m[3] ^ m[2]} ^ d;
    endfunction

    function automatic logic [3:0] golden_sig(
        input logic [3:0] s,
        input int         n
    );
        logic [3:0] m;
        logic [3:0] p;
        m = 4'b0000;
        p = s;
        for (int i = 0; i < n; i++) begin
            m = misr_step(m, p);
            p = {p[2:0], p[3] ^ p[2]};
        end
        return m;
    endfunction

    localparam logic [3:0] GOLD = golden_sig(4'b0101, 6);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] seed = 4'b0000;
    logic [7:0] num = 8'd0;
    logic [3:0] flip = 4'b0000;
    logic [3:0] misr = 4'b0000;
    logic [3:0] sig2 = 4'b0000;

    logic [3:0] pat;
    logic       pv, mr, me, busy, done, pass;
    logic [3:0] pat2;
    logic       pv2, mr2, me2, busy2, done2, pass2;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int t0;
    int k;

    logic [3:0]  seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                              4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC,
                              4'h8};
    logic [3:0]  exp1 [4] = '{4'h1, 4'h2, 4'h4, 4'h9};
    logic [15:0] seen;

    bist_tpg_controller #(
        .GOLDEN (GOLD)
    ) u_main (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .seed          (seed),
        .num_patterns  (num),
        .hold          (hold),
        .signature_in  (misr),
        .pattern       (pat),
        .pattern_valid (pv),
        .misr_reset    (mr),
        .misr_enable   (me),
        .busy          (busy),
        .done          (done),
        .pass          (pass)
    );

    bist_tpg_controller #(
        .CUT_LATENCY (2)
    ) u_lat (
        .clock         (clock),
        .reset         (reset),
        .start         (start2),
        .seed          (seed),
        .num_patterns  (num),
        .hold          (hold),
        .signature_in  (sig2),
        .pattern       (pat2),
        .pattern_valid (pv2),
        .misr_reset    (mr2),
        .misr_enable   (me2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference MISR fed by an identity CUT plus an optional error mask
    always @(posedge clock) begin
        if (mr) misr <= 4'b0000;
        else if (me) misr <= misr_step(misr, pat ^ flip);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic [3:0] s, input logic [7:0] n);
        seed  = s;
        num   = n;
        start = 1'b1;
        next();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            next();
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_inj(input int inj);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        start_run(4'b0101, 8'd6);
        while (done !== 1'b1 && n < 50) begin
            next();
            n++;
            flip = (pv && idx == inj) ? 4'b0100 : 4'b0000;
            if (pv) idx++;
        end
        flip = 4'b0000;
        chk("inj_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) next();
        reset = 1'b0;
        chk("rst_pattern", 32'(pat), 32'd0);
        chk("rst_strobes", 32'({pv, me, mr}), 32'd0);
        chk("rst_status", 32'({busy, done, pass}), 32'd0);

        // Test 1: seed 0001, N=4
        t0 = cyc;
        start_run(4'b0001, 8'd4);
        chk("t1_clear_mr", 32'(mr), 32'd1);
        chk("t1_clear_busy", 32'(busy), 32'd1);
        chk("t1_clear_pv", 32'(pv), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next();
            chk("t1_pattern", 32'(pat), 32'(exp1[i]));
            chk("t1_pv", 32'({pv, me, mr}), 32'b110);
        end
        next();
        chk("t1_cmp_pv", 32'({pv, me}), 32'd0);
        chk("t1_cmp_pat", 32'(pat), 32'h9);
        chk("t1_cmp_busy", 32'({busy, done}), 32'b10);
        next();
        chk("t1_done", 32'({busy, done}), 32'b01);
        chk("t1_latency", 32'(cyc - t0), 32'd7);

        // Test 2: seed 0 and N=0 give the full 15-pattern period
        seen = '0;
        t0 = cyc;
        start_run(4'b0000, 8'd0);
        for (int i = 0; i < 15; i++) begin
            next();
            chk("t2_pattern", 32'(pat), 32'(seq[i]));
            chk("t2_pv", 32'(pv), 32'd1);
            chk("t2_distinct", 32'(seen[pat]), 32'd0);
            seen[pat] = 1'b1;
        end
        wait_done(10);
        chk("t2_latency", 32'(cyc - t0), 32'd18);
        chk("t2_lfsr_wrap", 32'(u_main.lfsr), 32'h1);

        // Test 3: hold for 3 cycles after the 2nd pattern
        t0 = cyc;
        start_run(4'b0001, 8'd4);
        next();
        chk("t3_p1", 32'(pat), 32'h1);
        next();
        chk("t3_p2", 32'(pat), 32'h2);
        for (int i = 0; i < 3; i++) begin
            next();
            hold = 1'b1;
            #1;
            chk("t3_hold_strobes", 32'({pv, me}), 32'd0);
            chk("t3_hold_pat", 32'(pat), 32'h4);
        end
        next();
        hold = 1'b0;
        #1;
        chk("t3_p3", 32'({pat, pv}), 32'({4'h4, 1'b1}));
        next();
        chk("t3_p4", 32'({pat, pv}), 32'({4'h9, 1'b1}));
        wait_done(10);
        chk("t3_latency", 32'(cyc - t0), 32'd10);

        // Test 4: signature check, clean then with one flipped bit
        run_inj(-1);
        chk("t4_pass", 32'(pass), 32'd1);
        run_inj(2);
        chk("t4_fail", 32'(pass), 32'd0);

        // Test 5: start during RUN is ignored
        t0 = cyc;
        start_run(4'b0001, 8'd4);
        next();
        next();
        start = 1'b1;
        seed  = 4'b1000;
        num   = 8'd2;
        next();
        start = 1'b0;
        chk("t5_ignore_pat", 32'(pat), 32'h4);
        chk("t5_ignore_busy", 32'({busy, pv}), 32'b11);
        next();
        chk("t5_p4", 32'(pat), 32'h9);
        wait_done(10);
        chk("t5_latency", 32'(cyc - t0), 32'd7);

        // Test 5b: reset mid-RUN, then a fresh run
        start_run(4'b0001, 8'd4);
        next();
        next();
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        chk("t5_rst_state", 32'(u_main.state), 32'd0);
        chk("t5_rst_pat", 32'(pat), 32'd0);
        chk("t5_rst_outs", 32'({pv, me, mr, busy, done, pass}), 32'd0);
        t0 = cyc;
        start_run(4'b0001, 8'd4);
        next();
        chk("t5_fresh_p1", 32'({pat, pv}), 32'({4'h1, 1'b1}));
        wait_done(10);
        chk("t5_fresh_lat", 32'(cyc - t0), 32'd7);

        // Test 6: CUT_LATENCY=2 flush and restart from DONE
        t0 = cyc;
        seed   = 4'b0001;
        num    = 8'd3;
        start2 = 1'b1;
        next();
        start2 = 1'b0;
        chk("t6_clear_mr", 32'(mr2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            next();
            chk("t6_run", 32'({pv2, me2}), 32'b11);
        end
        for (int i = 0; i < 2; i++) begin
            next();
            chk("t6_flush", 32'({pv2, me2, busy2}), 32'b011);
        end
        next();
        chk("t6_compare", 32'({me2, busy2, done2}), 32'b010);
        next();
        chk("t6_done", 32'({busy2, done2, pass2}), 32'b011);
        chk("t6_latency", 32'(cyc - t0), 32'd8);
        start2 = 1'b1;
        next();
        start2 = 1'b0;
        chk("t6_restart", 32'({mr2, busy2, done2, pass2}), 32'b1100);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
